// File: rtl/dac_spi_tx_pkg.sv
// Shared types and frame layout for the MCP4921-style DAC SPI transmitter.
// Frame is {A/B, BUF, GA_n, SHDN_n, code[11:0]}, shifted MSB first.
package dac_spi_pkg;

    localparam int FRAME_W    = 16;
    localparam int CODE_W     = 12;
    localparam int BIT_AB     = 15;
    localparam int BIT_BUF    = 14;
    localparam int BIT_GA_N   = 13;
    localparam int BIT_SHDN_N = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_CS_HIGH,
        ST_LDAC
    } state_t;

    // Two's complement to offset binary is just an MSB flip.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [CODE_W-1:0] sample,
        input logic              is_signed,
        input logic              vref_buf,
        input logic              gain_1x,
        input logic              shdn_n
    );
        logic [FRAME_W-1:0] frame;
        frame                = '0;
        frame[CODE_W-1:0]    = is_signed ? {~sample[CODE_W-1], sample[CODE_W-2:0]} : sample;
        frame[BIT_SHDN_N]    = shdn_n;
        frame[BIT_GA_N]      = gain_1x;
        frame[BIT_BUF]       = vref_buf;
        frame[BIT_AB]        = 1'b0;
        return frame;
    endfunction

endpackage

// File: rtl/dac_spi_tx_sck_tick_gen.sv
// Half-period timer: o_tick is high on the last clk cycle of each CLK_DIV-cycle phase.
// i_restart zeroes the count so every new FSM state starts a fresh phase.
module sck_tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI master for an MCP4921-style 12-bit DAC: 1-deep sample holding register,
// 16-bit mode-0 frame, then an LDAC_n strobe so updates land on a frame boundary.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int CLK_DIV     = 1,
    parameter int DATA_SIGNED = 1,
    parameter int GAIN_1X     = 1,
    parameter int VREF_BUF    = 0,
    parameter int LDAC_PULSE  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_sample_in,
    input  logic              i_sample_valid,
    output logic              o_sample_ready,
    input  logic              i_dac_enable,
    output logic              o_dac_cs_n,
    output logic              o_dac_sck,
    output logic              o_dac_sdi,
    output logic              o_dac_ldac_n,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int         LCW       = (LDAC_PULSE > 1) ? $clog2(LDAC_PULSE) : 1;
    localparam logic [4:0] LAST_BIT  = 5'(FRAME_W - 1);
    localparam logic [4:0] ALL_BITS  = 5'(FRAME_W);
    localparam logic [LCW-1:0] LDAC_LAST = LCW'(LDAC_PULSE - 1);

    state_t             r_state, w_state_next;
    logic [DATA_W-1:0]  r_hold_data;
    logic               r_hold_full, w_hold_full_next;
    logic [FRAME_W-1:0] r_shift, w_shift_next;
    logic [4:0]         r_bit_cnt, w_bit_cnt_next;
    logic [LCW-1:0]     r_ldac_cnt, w_ldac_cnt_next;
    logic               w_load, w_accept, w_tick, w_in_frame;

    logic r_ready, r_cs_n, r_sck, r_sdi, r_ldac_n, r_busy, r_frame_done;

    sck_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (w_state_next != r_state),
        .o_tick    (w_tick)
    );

    assign w_accept         = i_sample_valid && r_ready;
    assign w_hold_full_next = w_load ? 1'b0 : (w_accept ? 1'b1 : r_hold_full);

    always_comb begin
        w_state_next    = r_state;
        w_load          = 1'b0;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_ldac_cnt_next = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_load         = 1'b1;
                    w_shift_next   = build_frame(r_hold_data, DATA_SIGNED != 0, VREF_BUF != 0,
                                                 GAIN_1X != 0, i_dac_enable);
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tick) w_state_next = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (w_tick) begin
                    w_state_next   = ST_SHIFT_LO;
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    // Bit 0 stays on SDI through the final low phase.
                    if (r_bit_cnt != LAST_BIT) w_shift_next = {r_shift[FRAME_W-2:0], 1'b0};
                end
            end
            ST_SHIFT_LO: begin
                if (w_tick) w_state_next = (r_bit_cnt == ALL_BITS) ? ST_CS_HIGH : ST_SHIFT_HI;
            end
            ST_CS_HIGH: begin
                if (w_tick) w_state_next = ST_LDAC;
            end
            ST_LDAC: begin
                if (r_ldac_cnt == LDAC_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_ldac_cnt_next = r_ldac_cnt + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_in_frame = (w_state_next == ST_SETUP) || (w_state_next == ST_SHIFT_HI) ||
                        (w_state_next == ST_SHIFT_LO);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_hold_data  <= '0;
            r_hold_full  <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_ldac_cnt   <= '0;
            r_ready      <= 1'b1;
            r_cs_n       <= 1'b1;
            r_sck        <= 1'b0;
            r_sdi        <= 1'b0;
            r_ldac_n     <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_hold_full  <= w_hold_full_next;
            r_shift      <= w_shift_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_ldac_cnt   <= w_ldac_cnt_next;
            if (w_accept) r_hold_data <= i_sample_in;
            // Outputs are registered from next-state so they line up with r_state.
            r_ready      <= !w_hold_full_next;
            r_cs_n       <= !w_in_frame;
            r_sck        <= (w_state_next == ST_SHIFT_HI);
            r_sdi        <= w_in_frame ? w_shift_next[FRAME_W-1] : 1'b0;
            r_ldac_n     <= (w_state_next != ST_LDAC);
            r_busy       <= (w_state_next != ST_IDLE);
            r_frame_done <= (w_state_next == ST_LDAC) && (w_ldac_cnt_next == LDAC_LAST);
        end
    end

    assign o_sample_ready = r_ready;
    assign o_dac_cs_n     = r_cs_n;
    assign o_dac_sck      = r_sck;
    assign o_dac_sdi      = r_sdi;
    assign o_dac_ldac_n   = r_ldac_n;
    assign o_busy         = r_busy;
    assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: three instances (defaults, unsigned, CLK_DIV=3)
// sharing clock and reset; one monitor decodes the SPI frame of the selected instance.
module tb_dac_spi_tx;

    logic        clk;
    logic        rst_n;
    logic [11:0] sample [3];
    logic        valid  [3];
    logic        en     [3];
    logic        ready  [3];
    logic        cs_n   [3];
    logic        sck    [3];
    logic        sdi    [3];
    logic        ldac_n [3];
    logic        busy   [3];
    logic        done   [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int sel    = 0;

    logic m_cs_n, m_sck, m_sdi, m_ldac_n, m_busy, m_done, m_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dac_spi_tx u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_in(sample[0]), .i_sample_valid(valid[0]),
        .o_sample_ready(ready[0]), .i_dac_enable(en[0]), .o_dac_cs_n(cs_n[0]),
        .o_dac_sck(sck[0]), .o_dac_sdi(sdi[0]), .o_dac_ldac_n(ldac_n[0]),
        .o_busy(busy[0]), .o_frame_done(done[0])
    );

    dac_spi_tx #(.DATA_SIGNED(0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_in(sample[1]), .i_sample_valid(valid[1]),
        .o_sample_ready(ready[1]), .i_dac_enable(en[1]), .o_dac_cs_n(cs_n[1]),
        .o_dac_sck(sck[1]), .o_dac_sdi(sdi[1]), .o_dac_ldac_n(ldac_n[1]),
        .o_busy(busy[1]), .o_frame_done(done[1])
    );

    dac_spi_tx #(.CLK_DIV(3)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_in(sample[2]), .i_sample_valid(valid[2]),
        .o_sample_ready(ready[2]), .i_dac_enable(en[2]), .o_dac_cs_n(cs_n[2]),
        .o_dac_sck(sck[2]), .o_dac_sdi(sdi[2]), .o_dac_ldac_n(ldac_n[2]),
        .o_busy(busy[2]), .o_frame_done(done[2])
    );

    always_comb begin
        m_cs_n   = cs_n[sel];
        m_sck    = sck[sel];
        m_sdi    = sdi[sel];
        m_ldac_n = ldac_n[sel];
        m_busy   = busy[sel];
        m_done   = done[sel];
        m_ready  = ready[sel];
    end

    // One-cycle valid pulse on an idle instance; returns at the negedge after the accept edge.
    task automatic send_one(input int which, input logic [11:0] s);
        @(negedge clk);
        sample[which] = s;
        valid[which]  = 1'b1;
        @(negedge clk);
        valid[which]  = 1'b0;
    endtask

    // Decodes one frame of the selected instance, sampling at negedges.
    task automatic collect_frame(input int div, output logic [15:0] frame, output int wait_c,
                                 output int busy_c, output int cs_c, output int rises,
                                 output int sdi_bad, output int sck_bad, output int hi_bad,
                                 output int ldac_gap, output int ldac_c, output int done_c,
                                 output bit to);
        int   cs_rise, ldac_first, hi_run;
        logic p_sck, p_sdi, p_cs;
        frame = '0; wait_c = 0; busy_c = 0; cs_c = 0; rises = 0; sdi_bad = 0;
        sck_bad = 0; hi_bad = 0; ldac_gap = -1; ldac_c = 0; done_c = 0; to = 1'b0;
        cs_rise = -1; ldac_first = -1; hi_run = 0;
        @(negedge clk);
        while (!m_busy) begin
            if (wait_c >= 400) begin to = 1'b1; return; end
            wait_c++;
            @(negedge clk);
        end
        p_sck = 1'b0; p_sdi = m_sdi; p_cs = 1'b1;
        while (m_busy) begin
            if (busy_c >= 2000) begin to = 1'b1; return; end
            if (!m_cs_n) cs_c++;
            if (m_cs_n && !p_cs && cs_rise < 0) cs_rise = busy_c;
            if (m_sck && m_cs_n) sck_bad++;
            if (m_sck && !p_sck) begin
                rises++;
                frame = {frame[14:0], m_sdi};
                if (m_sdi !== p_sdi) sdi_bad++;
            end
            if (m_sck) hi_run++;
            else if (p_sck) begin
                if (hi_run != div) hi_bad++;
                hi_run = 0;
            end
            if (!m_ldac_n) begin
                ldac_c++;
                if (ldac_first < 0) ldac_first = busy_c;
            end
            if (m_done) done_c++;
            p_sck = m_sck; p_sdi = m_sdi; p_cs = m_cs_n;
            busy_c++;
            @(negedge clk);
        end
        ldac_gap = ldac_first - cs_rise;
    endtask

    task automatic test_reset();
        logic [6:0] v;
        int         bcnt;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            v = {m_cs_n, m_sck, m_sdi, m_ldac_n, m_busy, m_done, m_ready};
            n_cmp++;
            if (v !== 7'b1001001) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: got %b want 1001001", i, v);
            end
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send_one(0, 12'h7FF);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (m_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prebusy: busy got %b want 1", m_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        v = {m_cs_n, m_sck, m_sdi, m_ldac_n, m_busy, m_done, m_ready};
        n_cmp++;
        if (v !== 7'b1001001) begin
            n_fail++;
            $display("FAIL reset_midframe: got %b want 1001001", v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_busy !== 1'b0 || m_cs_n !== 1'b1) bcnt++;
        end
        n_cmp++;
        if (bcnt != 0) begin
            n_fail++;
            $display("FAIL reset_discard: active cycles after reset got %0d want 0", bcnt);
        end
        $display("reset: checked reset values and mid-frame abort");
    endtask

    task automatic test_single();
        logic [15:0] f;
        int w, b, c, r, sb, kb, hb, g, lc, dc;
        bit to;
        sel = 0;
        en[0] = 1'b1;
        send_one(0, 12'h800);
        n_cmp++;
        if (m_ready !== 1'b0 || m_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: ready/cs_n got %b%b want 01", m_ready, m_cs_n);
        end
        collect_frame(1, f, w, b, c, r, sb, kb, hb, g, lc, dc, to);
        n_cmp++;
        if (to || f !== 16'h3000) begin
            n_fail++;
            $display("FAIL single_frame: got %h (timeout %0d) want 3000", f, to);
        end
        n_cmp++;
        if (w != 0) begin n_fail++; $display("FAIL single_latency: extra wait got %0d want 0", w); end
        n_cmp++;
        if (r != 16) begin n_fail++; $display("FAIL single_rises: got %0d want 16", r); end
        n_cmp++;
        if (c != 33) begin n_fail++; $display("FAIL single_cs_low: got %0d want 33", c); end
        n_cmp++;
        if (b != 35) begin n_fail++; $display("FAIL single_busy: got %0d want 35", b); end
        n_cmp++;
        if (g != 1 || lc != 1) begin
            n_fail++;
            $display("FAIL single_ldac: gap %0d len %0d want gap 1 len 1", g, lc);
        end
        n_cmp++;
        if (dc != 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", dc); end
        n_cmp++;
        if (sb != 0 || kb != 0 || hb != 0) begin
            n_fail++;
            $display("FAIL single_protocol: sdi %0d sck %0d half %0d want 0 0 0", sb, kb, hb);
        end
        $display("single: frame %h busy %0d cs_low %0d rises %0d", f, b, c, r);
    endtask

    task automatic test_codes();
        int          wh [4] = '{0, 0, 1, 1};
        logic [11:0] s  [4] = '{12'h7FF, 12'h000, 12'h123, 12'hABC};
        logic        e  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] x  [4] = '{16'h3FFF, 16'h3800, 16'h3123, 16'h2ABC};
        logic [15:0] f;
        int w, b, c, r, sb, kb, hb, g, lc, dc;
        bit to;
        for (int i = 0; i < 4; i++) begin
            sel = wh[i];
            en[wh[i]] = e[i];
            send_one(wh[i], s[i]);
            collect_frame(1, f, w, b, c, r, sb, kb, hb, g, lc, dc, to);
            n_cmp++;
            if (to || f !== x[i] || r != 16) begin
                n_fail++;
                $display("FAIL code_frame%0d: got %h rises %0d want %h rises 16", i, f, r, x[i]);
            end
            $display("code: dut%0d sample %h en %b frame %h", wh[i], s[i], e[i], f);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] s  [3] = '{12'h800, 12'h001, 12'h555};
        logic [15:0] x  [3] = '{16'h3000, 16'h3801, 16'h3D55};
        logic [15:0] fr [3];
        int          wt [3];
        int          acc, viol, extra;
        sel = 0;
        en[0] = 1'b1;
        acc = 0; viol = 0;
        fork
            begin
                int   g;
                logic rec;
                g = 0;
                @(negedge clk);
                sample[0] = s[0];
                valid[0]  = 1'b1;
                rec = ready[0];
                while (acc < 3 && g < 600) begin
                    @(negedge clk);
                    g++;
                    if (rec) begin
                        acc++;
                        if (ready[0] !== 1'b0) viol++;
                        if (acc < 3) sample[0] = s[acc];
                        else valid[0] = 1'b0;
                    end
                    rec = ready[0];
                end
                valid[0] = 1'b0;
            end
            begin
                int b, c, r, sb, kb, hb, g2, lc, dc;
                bit to;
                for (int k = 0; k < 3; k++)
                    collect_frame(1, fr[k], wt[k], b, c, r, sb, kb, hb, g2, lc, dc, to);
            end
        join
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (fr[k] !== x[k]) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: got %h want %h", k, fr[k], x[k]);
            end
            $display("b2b: frame %0d %h idle_extra %0d", k, fr[k], wt[k]);
        end
        n_cmp++;
        if (wt[1] != 0 || wt[2] != 0) begin
            n_fail++;
            $display("FAIL b2b_gap: extra idle got %0d,%0d want 0,0", wt[1], wt[2]);
        end
        n_cmp++;
        if (acc != 3 || viol != 0) begin
            n_fail++;
            $display("FAIL b2b_handshake: accepts %0d ready_viol %0d want 3 0", acc, viol);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_busy) extra++;
        end
        n_cmp++;
        if (extra != 0) begin n_fail++; $display("FAIL b2b_dup: busy cycles got %0d want 0", extra); end
    endtask

    task automatic test_clk_div3();
        logic [15:0] f;
        int w, b, c, r, sb, kb, hb, g, lc, dc;
        bit to;
        sel = 2;
        en[2] = 1'b1;
        send_one(2, 12'h800);
        fork
            collect_frame(3, f, w, b, c, r, sb, kb, hb, g, lc, dc, to);
            begin
                repeat (30) @(negedge clk);
                en[2] = 1'b0;
            end
        join
        n_cmp++;
        if (to || f !== 16'h3000) begin n_fail++; $display("FAIL div3_frame: got %h want 3000", f); end
        n_cmp++;
        if (c != 99 || b != 103) begin
            n_fail++;
            $display("FAIL div3_timing: cs_low %0d busy %0d want 99 103", c, b);
        end
        n_cmp++;
        if (r != 16 || hb != 0 || sb != 0 || kb != 0) begin
            n_fail++;
            $display("FAIL div3_protocol: rises %0d half %0d sdi %0d sck %0d want 16 0 0 0",
                     r, hb, sb, kb);
        end
        n_cmp++;
        if (g != 3 || lc != 1 || dc != 1) begin
            n_fail++;
            $display("FAIL div3_ldac: gap %0d len %0d done %0d want 3 1 1", g, lc, dc);
        end
        $display("div3: frame %h busy %0d cs_low %0d", f, b, c);
        send_one(2, 12'h123);
        collect_frame(3, f, w, b, c, r, sb, kb, hb, g, lc, dc, to);
        n_cmp++;
        if (to || f !== 16'h2923) begin n_fail++; $display("FAIL div3_enable: got %h want 2923", f); end
        $display("div3: frame %h after enable low", f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample[i] = '0;
            valid[i]  = 1'b0;
            en[i]     = 1'b1;
        end
        test_reset();
        test_single();
        test_codes();
        test_back_to_back();
        test_clk_div3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
